// File: rtl/transmitter_frame_scheduler_pkg.sv
// Shared constants, state encoding and helper functions for the transmit frame scheduler.
// TX_SCHED_SKP_INSERT_EN adds the SKP_INS state and the forced-SKP interval default.
package transmitter_frame_scheduler_pkg;

   localparam int         DEFAULT_TLP_WIDTH       = 32;
   localparam int         CONFIG_DLLP_WIDTH       = 16;
   localparam int         CONFIG_TLP_ID_WIDTH     = 3;
   localparam logic [7:0] DEFAULT_CRC_POLY        = 8'h07;
   localparam logic [7:0] DEFAULT_CRC_INIT        = 8'h00;
   localparam int         TX_SCHED_DLLP_BURST_MAX = 2;
`ifdef TX_SCHED_SKP_INSERT_EN
   localparam int         TX_SCHED_SKP_INTERVAL   = 256;
`endif

   localparam logic [7:0] K_CODE_SKP        = 8'h1C;
   localparam logic [7:0] K_CODE_START_TLP  = 8'hFB;
   localparam logic [7:0] K_CODE_START_DLLP = 8'h5C;
   localparam logic [7:0] K_CODE_STOP       = 8'hFD;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_PAYLOAD,
      ST_CRC,
      ST_STOP
`ifdef TX_SCHED_SKP_INSERT_EN
      , ST_SKP_INS
`endif
   } tx_state_e;

   function automatic int fun_sizeof_byte(input int bits);
      return (bits + 7) / 8;
   endfunction

   function automatic int fun_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // MSB-first, non-reflected CRC-8 over one byte.
   function automatic logic [7:0] crc_8(input logic [7:0] crc, input logic [7:0] data,
                                        input logic [7:0] poly);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ({c[6:0], 1'b0} ^ poly) : {c[6:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/transmitter_frame_scheduler_if.sv
// Request/grant handshakes of both requesters plus the physical byte lane.
interface transmitter_frame_scheduler_if
   import transmitter_frame_scheduler_pkg::*;
#(
   parameter int TLP_WIDTH    = DEFAULT_TLP_WIDTH,
   parameter int DLLP_WIDTH   = CONFIG_DLLP_WIDTH,
   parameter int TLP_ID_WIDTH = CONFIG_TLP_ID_WIDTH
) ();

   logic [TLP_WIDTH-1:0]          i_tlp;
   logic [2*(TLP_ID_WIDTH+1)-1:0] i_tlp_header;
   logic                          i_tlp_valid;
   logic                          o_tlp_rdy;
   logic [DLLP_WIDTH-1:0]         i_dllp;
   logic                          i_dllp_valid;
   logic                          o_dllp_rdy;
   logic                          o_phys_k_en;
   logic [7:0]                    o_phys_byte;

   modport master (
      output i_tlp, i_tlp_header, i_tlp_valid, i_dllp, i_dllp_valid,
      input  o_tlp_rdy, o_dllp_rdy, o_phys_k_en, o_phys_byte
   );

   modport slave (
      input  i_tlp, i_tlp_header, i_tlp_valid, i_dllp, i_dllp_valid,
      output o_tlp_rdy, o_dllp_rdy, o_phys_k_en, o_phys_byte
   );

endinterface

// File: rtl/transmitter_frame_arbiter.sv
// Grant logic between DLLP and TLP requesters; DLLP has priority until it has won
// DLLP_BURST_MAX times in a row while a TLP was waiting.
module transmitter_frame_arbiter
   import transmitter_frame_scheduler_pkg::*;
#(
   parameter int DLLP_BURST_MAX = TX_SCHED_DLLP_BURST_MAX
) (
   input  logic clk,
   input  logic rst_n,
   input  logic arb_en,
   input  logic tlp_valid,
   input  logic dllp_valid,
   output logic grant_tlp,
   output logic grant_dllp
);

   localparam int BW = fun_max(1, $clog2(DLLP_BURST_MAX + 1));

   logic [BW-1:0] burst_cnt_p0;
   logic          tlp_turn;

   assign tlp_turn   = tlp_valid && (burst_cnt_p0 == BW'(DLLP_BURST_MAX));
   assign grant_dllp = arb_en && dllp_valid && !tlp_turn;
   assign grant_tlp  = arb_en && tlp_valid && !grant_dllp;

   // stage p0: burst counter only advances while a TLP is being starved
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         burst_cnt_p0 <= '0;
      end else if (!tlp_valid || grant_tlp) begin
         burst_cnt_p0 <= '0;
      end else if (grant_dllp) begin
         burst_cnt_p0 <= burst_cnt_p0 + 1'b1;
      end
   end

endmodule

// File: rtl/transmitter_frame_scheduler.sv
// Transmit lane scheduler: arbitrates DLLP/TLP requests and frames them as
// start K, payload, CRC-8, stop K; SKP fills the lane. TX_SCHED_SKP_INSERT_EN forces periodic SKP.
module transmitter_frame_scheduler
   import transmitter_frame_scheduler_pkg::*;
#(
   parameter int         TLP_WIDTH      = DEFAULT_TLP_WIDTH,
   parameter int         DLLP_WIDTH     = CONFIG_DLLP_WIDTH,
   parameter int         TLP_ID_WIDTH   = CONFIG_TLP_ID_WIDTH,
   parameter logic [7:0] CRC_POLY       = DEFAULT_CRC_POLY,
   parameter logic [7:0] CRC_INIT       = DEFAULT_CRC_INIT,
`ifdef TX_SCHED_SKP_INSERT_EN
   parameter int         SKP_INTERVAL   = TX_SCHED_SKP_INTERVAL,
`endif
   parameter int         DLLP_BURST_MAX = TX_SCHED_DLLP_BURST_MAX
) (
   input  logic                           i_clk,
   input  logic                           i_arst_n,
   transmitter_frame_scheduler_if.slave   bus
);

   localparam int HDR_W       = 2 * (TLP_ID_WIDTH + 1);
   localparam int TLP_FRAME_W = TLP_WIDTH + HDR_W;
   localparam int TLP_BYTES   = fun_sizeof_byte(TLP_FRAME_W);
   localparam int DLLP_BYTES  = fun_sizeof_byte(DLLP_WIDTH);
   localparam int MAX_BYTES   = fun_max(TLP_BYTES, DLLP_BYTES);
   localparam int SR_W        = MAX_BYTES * 8;
   localparam int CNT_W       = fun_max(1, $clog2(MAX_BYTES));

   localparam logic [CNT_W-1:0] TLP_CNT_INIT  = CNT_W'(TLP_BYTES - 1);
   localparam logic [CNT_W-1:0] DLLP_CNT_INIT = CNT_W'(DLLP_BYTES - 1);

   logic [1:0]       rst_sync;
   logic             rst_n;
   tx_state_e        state_p0, nxt_state, arb_next;
   logic [SR_W-1:0]  sr_p0, tlp_frame, dllp_frame;
   logic [7:0]       crc_p0;
   logic [CNT_W-1:0] cnt_p0;
   logic             ftype_p0;
   logic             arb_en, grant_tlp, grant_dllp;
   logic             lane_k;
   logic [7:0]       lane_byte;
   logic             lane_k_p1, tlp_rdy_p1, dllp_rdy_p1;
   logic [7:0]       lane_byte_p1;

   // Assert asynchronously, release synchronously.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end
   assign rst_n = rst_sync[1];

   // Frames are MSB-aligned so the shift register always emits from its top byte.
   always_comb begin
      tlp_frame                          = '0;
      tlp_frame[SR_W-1 -: TLP_FRAME_W]   = {bus.i_tlp, bus.i_tlp_header};
      dllp_frame                         = '0;
      dllp_frame[SR_W-1 -: DLLP_WIDTH]   = bus.i_dllp;
   end

`ifdef TX_SCHED_SKP_INSERT_EN
   localparam int SKP_CNT_W = $clog2(SKP_INTERVAL + 1);

   logic [SKP_CNT_W-1:0] skp_cnt_p0;
   logic                 skp_due;

   assign skp_due = (skp_cnt_p0 >= SKP_CNT_W'(SKP_INTERVAL));

   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         skp_cnt_p0 <= '0;
      end else if (lane_k && (lane_byte == K_CODE_SKP)) begin
         skp_cnt_p0 <= '0;
      end else if (!skp_due) begin
         skp_cnt_p0 <= skp_cnt_p0 + 1'b1;
      end
   end

   assign arb_en = ((state_p0 == ST_IDLE) || (state_p0 == ST_STOP)) && !skp_due;
`else
   assign arb_en = (state_p0 == ST_IDLE) || (state_p0 == ST_STOP);
`endif

   transmitter_frame_arbiter #(
      .DLLP_BURST_MAX (DLLP_BURST_MAX)
   ) u_arbiter (
      .clk        (i_clk),
      .rst_n      (rst_n),
      .arb_en     (arb_en),
      .tlp_valid  (bus.i_tlp_valid),
      .dllp_valid (bus.i_dllp_valid),
      .grant_tlp  (grant_tlp),
      .grant_dllp (grant_dllp)
   );

   always_comb begin
      arb_next = ST_IDLE;
      if (grant_tlp || grant_dllp) begin
         arb_next = ST_START;
      end
`ifdef TX_SCHED_SKP_INSERT_EN
      else if (skp_due) begin
         arb_next = ST_SKP_INS;
      end
`endif
   end

   always_comb begin
      nxt_state = state_p0;
      lane_k    = 1'b1;
      lane_byte = K_CODE_SKP;
      case (state_p0)
         ST_IDLE: begin
            nxt_state = arb_next;
         end
         ST_START: begin
            lane_byte = ftype_p0 ? K_CODE_START_TLP : K_CODE_START_DLLP;
            nxt_state = ST_PAYLOAD;
         end
         ST_PAYLOAD: begin
            lane_k    = 1'b0;
            lane_byte = sr_p0[SR_W-1 -: 8];
            if (cnt_p0 == '0) begin
               nxt_state = ST_CRC;
            end
         end
         ST_CRC: begin
            lane_k    = 1'b0;
            lane_byte = crc_p0;
            nxt_state = ST_STOP;
         end
         ST_STOP: begin
            lane_byte = K_CODE_STOP;
            nxt_state = arb_next;
         end
`ifdef TX_SCHED_SKP_INSERT_EN
         ST_SKP_INS: begin
            nxt_state = ST_IDLE;
         end
`endif
         default: begin
            nxt_state = ST_IDLE;
         end
      endcase
   end

   // stage p0: FSM and frame control
   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_p0 <= ST_IDLE;
         cnt_p0   <= '0;
         ftype_p0 <= 1'b0;
      end else begin
         state_p0 <= nxt_state;
         if (grant_tlp) begin
            cnt_p0   <= TLP_CNT_INIT;
            ftype_p0 <= 1'b1;
         end else if (grant_dllp) begin
            cnt_p0   <= DLLP_CNT_INIT;
            ftype_p0 <= 1'b0;
         end else if ((state_p0 == ST_PAYLOAD) && (cnt_p0 != '0)) begin
            cnt_p0 <= cnt_p0 - 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (grant_tlp) begin
         sr_p0 <= tlp_frame;
      end else if (grant_dllp) begin
         sr_p0 <= dllp_frame;
      end else if (state_p0 == ST_PAYLOAD) begin
         sr_p0 <= sr_p0 << 8;
      end
      if (state_p0 == ST_START) begin
         crc_p0 <= CRC_INIT;
      end else if (state_p0 == ST_PAYLOAD) begin
         crc_p0 <= crc_8(crc_p0, sr_p0[SR_W-1 -: 8], CRC_POLY);
      end
   end

   // stage p1: registered lane and grant pulses
   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_k_p1    <= 1'b1;
         lane_byte_p1 <= K_CODE_SKP;
         tlp_rdy_p1   <= 1'b0;
         dllp_rdy_p1  <= 1'b0;
      end else begin
         lane_k_p1    <= lane_k;
         lane_byte_p1 <= lane_byte;
         tlp_rdy_p1   <= grant_tlp;
         dllp_rdy_p1  <= grant_dllp;
      end
   end

   assign bus.o_phys_k_en = lane_k_p1;
   assign bus.o_phys_byte = lane_byte_p1;
   assign bus.o_tlp_rdy   = tlp_rdy_p1;
   assign bus.o_dllp_rdy  = dllp_rdy_p1;

endmodule

// File: tb/tb_transmitter_frame_scheduler.sv
// Directed bench for transmitter_frame_scheduler with a byte-level scoreboard of the lane.
module tb_transmitter_frame_scheduler;

   localparam int         TLP_W  = 32;
   localparam int         DLLP_W = 16;
   localparam int         ID_W   = 3;
   localparam logic [7:0] SKP    = 8'h1C;
   localparam logic [7:0] STA_T  = 8'hFB;
   localparam logic [7:0] STA_D  = 8'h5C;
   localparam logic [7:0] END_K  = 8'hFD;
   localparam logic [7:0] POLY   = 8'h07;
   localparam logic [7:0] INIT   = 8'h00;

   logic clk = 1'b0;
   logic arst_n = 1'b0;
   always #5 clk = ~clk;

   transmitter_frame_scheduler_if #(
      .TLP_WIDTH (TLP_W), .DLLP_WIDTH (DLLP_W), .TLP_ID_WIDTH (ID_W)
   ) bus ();

   transmitter_frame_scheduler #(
      .TLP_WIDTH (TLP_W), .DLLP_WIDTH (DLLP_W), .TLP_ID_WIDTH (ID_W),
      .CRC_POLY (POLY), .CRC_INIT (INIT), .DLLP_BURST_MAX (2)
   ) dut (
      .i_clk    (clk),
      .i_arst_n (arst_n),
      .bus      (bus)
   );

   int         n_asserts = 0;
   int         n_fail    = 0;
   logic [8:0] exp_q[$];

   // Bit-serial reference CRC.
   function automatic logic [7:0] crc_bit(input logic [7:0] c, input logic [7:0] d);
      logic fb;
      for (int i = 7; i >= 0; i--) begin
         fb = c[7] ^ d[i];
         c  = {c[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
      end
      return c;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_frame(input bit is_tlp, input logic [39:0] bits, input int nbytes);
      logic [7:0] c, b;
      exp_q.push_back({1'b1, is_tlp ? STA_T : STA_D});
      c = INIT;
      for (int i = 0; i < nbytes; i++) begin
         b = bits[8*(nbytes-1-i) +: 8];
         exp_q.push_back({1'b0, b});
         c = crc_bit(c, b);
      end
      exp_q.push_back({1'b0, c});
      exp_q.push_back({1'b1, END_K});
   endtask

   task automatic wait_rdy(input bit is_tlp, input int budget, input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (is_tlp ? bus.o_tlp_rdy : bus.o_dllp_rdy) begin
            seen = 1'b1;
            break;
         end
      end
      check(tag, {31'b0, seen}, 32'd1);
   endtask

   task automatic drain(input string tag, input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      check(tag, exp_q.size(), 32'd0);
   endtask

   // Every non-SKP lane byte must be the next expected frame byte.
   always @(negedge clk) begin
      if (arst_n && !(bus.o_phys_k_en && bus.o_phys_byte == SKP)) begin
         if (exp_q.size() == 0) begin
            n_asserts++;
            assert (exp_q.size() != 0) else begin
               n_fail++;
               $error("FAIL sb_unexpected: observed %h expected no frame byte",
                      {bus.o_phys_k_en, bus.o_phys_byte});
            end
         end else begin
            check("sb_byte", {23'b0, bus.o_phys_k_en, bus.o_phys_byte}, {23'b0, exp_q.pop_front()});
         end
      end
      if (bus.o_tlp_rdy || bus.o_dllp_rdy) begin
         check("rdy_exclusive", {31'b0, bus.o_tlp_rdy & bus.o_dllp_rdy}, 32'd0);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] dv[5];
      logic [39:0] tv[3];
      bit          ord[8];
      int          d_at, t_at, g, di, ti;
      logic [8:0]  lane_at_t;

      bus.i_tlp = '0; bus.i_tlp_header = '0; bus.i_tlp_valid = 1'b0;
      bus.i_dllp = '0; bus.i_dllp_valid = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_lane", {bus.o_phys_k_en, bus.o_phys_byte}, {1'b1, SKP});
      check("rst_tlp_rdy", {31'b0, bus.o_tlp_rdy}, 32'd0);
      check("rst_dllp_rdy", {31'b0, bus.o_dllp_rdy}, 32'd0);
      arst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("idle_lane", {bus.o_phys_k_en, bus.o_phys_byte}, {1'b1, SKP});

      // Single DLLP on an idle link
      bus.i_dllp = 16'hA55A; bus.i_dllp_valid = 1'b1;
      push_frame(1'b0, 40'hA55A, 2);
      wait_rdy(1'b0, 20, "t1_grant");
      bus.i_dllp_valid = 1'b0;
      @(negedge clk);
      check("t1_start", {bus.o_phys_k_en, bus.o_phys_byte}, {1'b1, STA_D});
      check("t1_rdy_pulse", {31'b0, bus.o_dllp_rdy}, 32'd0);
      repeat (4) @(negedge clk);
      check("t1_stop", {bus.o_phys_k_en, bus.o_phys_byte}, {1'b1, END_K});
      @(negedge clk);
      check("t1_skp_after", {bus.o_phys_k_en, bus.o_phys_byte}, {1'b1, SKP});
      check("t1_drain", exp_q.size(), 32'd0);

      // Simultaneous requests: DLLP first, TLP back-to-back at its STOP
      repeat (3) @(negedge clk);
      bus.i_dllp = 16'h1234; bus.i_dllp_valid = 1'b1;
      bus.i_tlp = 32'hDEADBEEF; bus.i_tlp_header = 8'h33; bus.i_tlp_valid = 1'b1;
      push_frame(1'b0, 40'h1234, 2);
      push_frame(1'b1, 40'hDEADBEEF33, 5);
      d_at = -1; t_at = -1; lane_at_t = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.o_dllp_rdy && d_at < 0) begin d_at = i; bus.i_dllp_valid = 1'b0; end
         if (bus.o_tlp_rdy) begin
            t_at = i; bus.i_tlp_valid = 1'b0;
            lane_at_t = {bus.o_phys_k_en, bus.o_phys_byte};
            break;
         end
      end
      check("t2_dllp_first", {31'b0, d_at >= 0 && t_at > d_at}, 32'd1);
      check("t2_tlp_rdy_delay", t_at - d_at, 32'd5);
      check("t2_tlp_at_stop", {23'b0, lane_at_t}, {23'b0, 1'b1, END_K});
      @(negedge clk);
      check("t2_no_gap", {bus.o_phys_k_en, bus.o_phys_byte}, {1'b1, STA_T});
      drain("t2_drain", 60);

      // Continuous DLLPs with a waiting TLP: D D T D D T D T
      dv = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505};
      tv = '{40'h1111111131, 40'h2222222232, 40'h3333333333};
      ord = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      di = 0; ti = 0;
      for (int k = 0; k < 8; k++) begin
         if (ord[k]) begin push_frame(1'b1, tv[ti], 5); ti++; end
         else        begin push_frame(1'b0, {24'b0, dv[di]}, 2); di++; end
      end
      di = 0; ti = 0; g = 0;
      bus.i_dllp = dv[0]; bus.i_dllp_valid = 1'b1;
      {bus.i_tlp, bus.i_tlp_header} = tv[0]; bus.i_tlp_valid = 1'b1;
      for (int i = 0; i < 400 && g < 8; i++) begin
         @(negedge clk);
         if (bus.o_tlp_rdy || bus.o_dllp_rdy) begin
            check($sformatf("t3_grant%0d_is_tlp", g), {31'b0, bus.o_tlp_rdy}, {31'b0, ord[g]});
            g++;
            if (bus.o_dllp_rdy) begin
               di++;
               if (di < 5) bus.i_dllp = dv[di]; else bus.i_dllp_valid = 1'b0;
            end
            if (bus.o_tlp_rdy) begin
               ti++;
               if (ti < 3) {bus.i_tlp, bus.i_tlp_header} = tv[ti]; else bus.i_tlp_valid = 1'b0;
            end
         end
      end
      check("t3_grant_count", g, 32'd8);
      drain("t3_drain", 100);

      // Reset during PAYLOAD abandons the frame
      repeat (2) @(negedge clk);
      bus.i_dllp = 16'hBEEF; bus.i_dllp_valid = 1'b1;
      push_frame(1'b0, 40'hBEEF, 2);
      wait_rdy(1'b0, 20, "t4_grant");
      bus.i_dllp_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2 arst_n = 1'b0;
      #1;
      check("t4_rst_lane", {bus.o_phys_k_en, bus.o_phys_byte}, {1'b1, SKP});
      check("t4_rst_dllp_rdy", {31'b0, bus.o_dllp_rdy}, 32'd0);
      check("t4_rst_tlp_rdy", {31'b0, bus.o_tlp_rdy}, 32'd0);
      exp_q.delete();
      @(negedge clk);
      arst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("t4_idle_lane", {bus.o_phys_k_en, bus.o_phys_byte}, {1'b1, SKP});
      bus.i_dllp = 16'h0F0F; bus.i_dllp_valid = 1'b1;
      push_frame(1'b0, 40'h0F0F, 2);
      wait_rdy(1'b0, 20, "t4_regrant");
      bus.i_dllp_valid = 1'b0;
      drain("t4_drain", 20);
      check("t4_skp_after", {bus.o_phys_k_en, bus.o_phys_byte}, {1'b1, SKP});

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
